// File: rtl/mem_share_ctrl.sv
// Two-requester front end for a single-port RAM: zero-fills the RAM after
// reset or on demand, then arbitrates accesses round-robin.
module mem_share_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int RAM_DEPTH  = 1 << ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear_start,
    output logic                  init_done,
    input  logic                  req_valid_0,
    output logic                  req_ready_0,
    input  logic                  req_we_0,
    input  logic [ADDR_WIDTH-1:0] req_addr_0,
    input  logic [DATA_WIDTH-1:0] req_wdata_0,
    output logic                  rsp_valid_0,
    output logic [DATA_WIDTH-1:0] rsp_data_0,
    input  logic                  req_valid_1,
    output logic                  req_ready_1,
    input  logic                  req_we_1,
    input  logic [ADDR_WIDTH-1:0] req_addr_1,
    input  logic [DATA_WIDTH-1:0] req_wdata_1,
    output logic                  rsp_valid_1,
    output logic [DATA_WIDTH-1:0] rsp_data_1,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    output logic                  mem_cs,
    output logic                  mem_we,
    output logic                  mem_oe,
    input  logic [DATA_WIDTH-1:0] mem_data_out
);

    typedef enum logic [1:0] {
        S_BOOT,
        S_CLEAR,
        S_RUN
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);

    state_t                  r_state;
    state_t                  w_next;
    logic [ADDR_WIDTH-1:0]   r_cnt;
    logic                    r_last;
    logic                    r_pend;
    logic                    r_owner;
    logic                    w_run;
    logic                    w_gnt0;
    logic                    w_gnt1;
    logic                    w_gnt;
    logic                    w_we;
    logic [ADDR_WIDTH-1:0]   w_addr;
    logic [DATA_WIDTH-1:0]   w_wdata;

    // A tie goes to whichever requester was not granted last.
    always_comb begin
        w_run   = (r_state == S_RUN) && !clear_start;
        w_gnt0  = w_run && req_valid_0 && (!req_valid_1 || r_last);
        w_gnt1  = w_run && req_valid_1 && (!req_valid_0 || !r_last);
        w_gnt   = w_gnt0 || w_gnt1;
        w_we    = w_gnt1 ? req_we_1    : req_we_0;
        w_addr  = w_gnt1 ? req_addr_1  : req_addr_0;
        w_wdata = w_gnt1 ? req_wdata_1 : req_wdata_0;
    end

    always_comb begin
        w_next      = r_state;
        mem_cs      = 1'b0;
        mem_we      = 1'b0;
        mem_oe      = 1'b0;
        mem_address = '0;
        mem_data_in = '0;
        case (r_state)
            S_BOOT: begin
                w_next = S_CLEAR;
            end
            S_CLEAR: begin
                mem_cs      = 1'b1;
                mem_we      = 1'b1;
                mem_address = r_cnt;
                if (r_cnt == LAST_ADDR) begin
                    w_next = S_RUN;
                end
            end
            S_RUN: begin
                if (clear_start) begin
                    w_next = S_CLEAR;
                end
                if (w_gnt) begin
                    mem_cs      = 1'b1;
                    mem_we      = w_we;
                    mem_oe      = !w_we;
                    mem_address = w_addr;
                    mem_data_in = w_wdata;
                end
            end
            default: begin
                w_next = S_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_BOOT;
            r_cnt   <= '0;
            r_last  <= 1'b1;
            r_pend  <= 1'b0;
            r_owner <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_CLEAR && r_cnt != LAST_ADDR) begin
                r_cnt <= r_cnt + 1'b1;
            end else begin
                r_cnt <= '0;
            end
            if (w_gnt) begin
                r_last  <= w_gnt1;
                r_owner <= w_gnt1;
            end
            r_pend <= w_gnt && !w_we;
        end
    end

    assign init_done   = (r_state == S_RUN);
    assign req_ready_0 = w_gnt0;
    assign req_ready_1 = w_gnt1;
    assign rsp_valid_0 = r_pend && !r_owner;
    assign rsp_valid_1 = r_pend && r_owner;
    assign rsp_data_0  = mem_data_out;
    assign rsp_data_1  = mem_data_out;

endmodule

// File: tb/tb_mem_share_ctrl.sv
// Bench for mem_share_ctrl: directed tables, clear/reset sequences and a
// randomized phase checked against an abstract arbitration/memory model.
module tb_mem_share_ctrl;

    typedef struct packed {
        logic        init;
        logic        r0;
        logic        r1;
        logic        cs;
        logic        we;
        logic        oe;
        logic        rv0;
        logic        rv1;
        logic [7:0]  addr;
        logic [31:0] din;
        logic [31:0] rd0;
        logic [31:0] rd1;
    } obs_t;

    // ctl = {v0, we0, v1, we1, clear_start}
    typedef struct packed {
        logic [4:0]  ctl;
        logic [7:0]  a0;
        logic [31:0] d0;
        logic [7:0]  a1;
        logic [31:0] d1;
        obs_t        exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear_start = 1'b0;
    logic        init_done;
    logic        req_valid_0 = 1'b0, req_we_0 = 1'b0;
    logic        req_valid_1 = 1'b0, req_we_1 = 1'b0;
    logic [7:0]  req_addr_0 = '0, req_addr_1 = '0;
    logic [31:0] req_wdata_0 = '0, req_wdata_1 = '0;
    logic        req_ready_0, req_ready_1;
    logic        rsp_valid_0, rsp_valid_1;
    logic [31:0] rsp_data_0, rsp_data_1;
    logic [7:0]  mem_address;
    logic [31:0] mem_data_in;
    logic        mem_cs, mem_we, mem_oe;
    logic [31:0] mem_data_out;

    logic [31:0] ram [256];
    logic [31:0] ram_q = '0;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_cs && mem_we) ram[mem_address] <= mem_data_in;
        ram_q <= (mem_cs && mem_oe) ? ram[mem_address] : '0;
    end
    assign mem_data_out = ram_q;

    mem_share_ctrl dut (
        .clk(clk), .rst_n(rst_n), .clear_start(clear_start),
        .init_done(init_done),
        .req_valid_0(req_valid_0), .req_ready_0(req_ready_0),
        .req_we_0(req_we_0), .req_addr_0(req_addr_0),
        .req_wdata_0(req_wdata_0), .rsp_valid_0(rsp_valid_0),
        .rsp_data_0(rsp_data_0),
        .req_valid_1(req_valid_1), .req_ready_1(req_ready_1),
        .req_we_1(req_we_1), .req_addr_1(req_addr_1),
        .req_wdata_1(req_wdata_1), .rsp_valid_1(rsp_valid_1),
        .rsp_data_1(rsp_data_1),
        .mem_address(mem_address), .mem_data_in(mem_data_in),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_oe(mem_oe),
        .mem_data_out(mem_data_out)
    );

    function automatic obs_t ob(logic [7:0] f, logic [7:0] a,
                                logic [31:0] d, logic [31:0] rd);
        return obs_t'({f, a, d, rd, rd});
    endfunction

    function automatic obs_t sample();
        return obs_t'({init_done, req_ready_0, req_ready_1, mem_cs, mem_we,
                       mem_oe, rsp_valid_0, rsp_valid_1, mem_address,
                       mem_data_in, rsp_data_0, rsp_data_1});
    endfunction

    task automatic chk(string nm, obs_t exp);
        obs_t act;
        act = sample();
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s got %h want %h (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(logic [4:0] c, logic [7:0] a0, logic [31:0] d0,
                         logic [7:0] a1, logic [31:0] d1);
        {req_valid_0, req_we_0, req_valid_1, req_we_1, clear_start} = c;
        req_addr_0 = a0; req_wdata_0 = d0;
        req_addr_1 = a1; req_wdata_1 = d1;
    endtask

    task automatic sweep(int lo, int hi);
        for (int k = lo; k <= hi; k++) begin
            cyc(); #1;
            chk($sformatf("clear[%0d]", k), ob(8'b00011000, 8'(k), '0, '0));
        end
    endtask

    task automatic boot_seq();
        cyc();
        rst_n = 1'b1;
        #1;
        chk("boot", ob(8'h00, '0, '0, '0));
    endtask

    vec_t tbl [9];

    initial begin
        logic        v [2];
        logic        w [2];
        logic [7:0]  a [2];
        logic [31:0] d [2];
        logic        clr;
        logic [31:0] mm [8];
        int          last, win, pwho, cidx;
        logic [31:0] pdata;
        bit          clearing;
        obs_t        e;

        tbl[0] = '{5'b11000, 8'h10, 32'hDEADBEEF, 8'h00, 32'h0,
                   ob(8'b11011000, 8'h10, 32'hDEADBEEF, 32'h0)};
        tbl[1] = '{5'b00100, 8'h00, 32'h0, 8'h10, 32'h0,
                   ob(8'b10110100, 8'h10, 32'h0, 32'h0)};
        tbl[2] = '{5'b00000, 8'h00, 32'h0, 8'h00, 32'h0,
                   ob(8'b10000001, 8'h00, 32'h0, 32'hDEADBEEF)};
        tbl[3] = '{5'b11110, 8'h20, 32'h11110000, 8'h21, 32'h22220000,
                   ob(8'b11011000, 8'h20, 32'h11110000, 32'h0)};
        tbl[4] = '{5'b11110, 8'h22, 32'h33330000, 8'h21, 32'h22220000,
                   ob(8'b10111000, 8'h21, 32'h22220000, 32'h0)};
        tbl[5] = '{5'b10100, 8'h20, 32'h0, 8'h21, 32'h0,
                   ob(8'b11010100, 8'h20, 32'h0, 32'h0)};
        tbl[6] = '{5'b10100, 8'h20, 32'h0, 8'h21, 32'h0,
                   ob(8'b10110110, 8'h21, 32'h0, 32'h11110000)};
        tbl[7] = '{5'b10100, 8'h20, 32'h0, 8'h21, 32'h0,
                   ob(8'b11010101, 8'h20, 32'h0, 32'h22220000)};
        tbl[8] = '{5'b00000, 8'h00, 32'h0, 8'h00, 32'h0,
                   ob(8'b10000010, 8'h00, 32'h0, 32'h11110000)};

        // Reset, boot and initial sweep with both requesters waiting.
        drive(5'b10100, 8'h03, '0, 8'h04, '0);
        #3;
        chk("reset", ob(8'h00, '0, '0, '0));
        boot_seq();
        sweep(0, 255);
        cyc(); #1;
        chk("first_run_grant", ob(8'b11010100, 8'h03, '0, '0));
        cyc(); drive(5'b00000, '0, '0, '0, '0); #1;
        chk("first_rsp", ob(8'b10000010, '0, '0, '0));

        for (int i = 0; i < 9; i++) begin
            cyc();
            drive(tbl[i].ctl, tbl[i].a0, tbl[i].d0, tbl[i].a1, tbl[i].d1);
            #1;
            chk($sformatf("tbl[%0d]", i), tbl[i].exp);
        end

        // Read granted, then clear_start: response still arrives.
        cyc(); drive(5'b00100, '0, '0, 8'h10, '0); #1;
        chk("rd_before_clr", ob(8'b10110100, 8'h10, '0, '0));
        cyc(); drive(5'b10101, 8'h10, '0, 8'h10, '0); #1;
        chk("clr_cycle", ob(8'b10000001, '0, '0, 32'hDEADBEEF));
        cyc(); drive(5'b10100, 8'h10, '0, 8'h10, '0); #1;
        chk("clear[0]", ob(8'b00011000, '0, '0, '0));
        sweep(1, 255);
        cyc(); drive(5'b10000, 8'h10, '0, '0, '0); #1;
        chk("rd_after_clr", ob(8'b11010100, 8'h10, '0, '0));
        cyc(); drive(5'b00000, '0, '0, '0, '0); #1;
        chk("rsp_after_clr", ob(8'b10000010, '0, '0, '0));

        // Pending read is dropped by reset.
        cyc(); drive(5'b10000, 8'h10, '0, '0, '0); #1;
        chk("rd_before_rst", ob(8'b11010100, 8'h10, '0, '0));
        #2;
        rst_n = 1'b0;
        drive(5'b10100, 8'h03, '0, 8'h04, '0);
        #1;
        chk("rst_async", ob(8'h00, '0, '0, '0));
        cyc(); #1;
        chk("rst_no_rsp", ob(8'h00, '0, '0, '0));
        boot_seq();
        sweep(0, 100);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_clear", ob(8'h00, '0, '0, '0));
        boot_seq();
        sweep(0, 255);
        cyc(); #1;
        chk("grant_after_rst", ob(8'b11010100, 8'h03, '0, '0));
        cyc(); drive(5'b00000, '0, '0, '0, '0); #1;
        chk("rsp_after_rst", ob(8'b10000010, '0, '0, '0));

        // Randomized phase against an abstract model.
        last = 0; pwho = -1; pdata = '0; clearing = 0; cidx = 0;
        for (int i = 0; i < 8; i++) mm[i] = '0;
        for (int n = 0; n < 600; n++) begin
            cyc();
            for (int r = 0; r < 2; r++) begin
                v[r] = ($urandom % 4) != 0;
                w[r] = $urandom % 2 == 1;
                a[r] = 8'($urandom % 8);
                d[r] = $urandom;
            end
            clr = ($urandom % 150) == 0;
            req_valid_0 = v[0]; req_we_0 = w[0];
            req_addr_0 = a[0]; req_wdata_0 = d[0];
            req_valid_1 = v[1]; req_we_1 = w[1];
            req_addr_1 = a[1]; req_wdata_1 = d[1];
            clear_start = clr;
            #1;
            e = '0;
            e.init = !clearing;
            if (pwho >= 0) begin
                e.rv0 = (pwho == 0);
                e.rv1 = (pwho == 1);
                e.rd0 = pdata;
                e.rd1 = pdata;
            end
            win = -1;
            if (clearing) begin
                e.cs = 1'b1; e.we = 1'b1; e.addr = 8'(cidx);
            end else if (!clr) begin
                if (v[0] && v[1]) win = 1 - last;
                else if (v[0]) win = 0;
                else if (v[1]) win = 1;
            end
            if (win >= 0) begin
                e.r0 = (win == 0); e.r1 = (win == 1);
                e.cs = 1'b1; e.we = w[win]; e.oe = !w[win];
                e.addr = a[win]; e.din = d[win];
            end
            chk($sformatf("rand[%0d]", n), e);
            pwho = -1;
            if (win >= 0) begin
                last = win;
                if (w[win]) mm[a[win][2:0]] = d[win];
                else begin
                    pwho = win;
                    pdata = mm[a[win][2:0]];
                end
            end
            if (clearing) begin
                cidx++;
                if (cidx == 256) clearing = 0;
            end else if (clr) begin
                clearing = 1;
                cidx = 0;
                for (int i = 0; i < 8; i++) mm[i] = '0;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
